cac_row_drain: RTL and testbench
================================

# cac_row_drain

Read-side counterpart to the result accumulator. It captures a completed DIM x DIM result matrix in one cycle. It then streams the matrix out one row (or column) per transfer over a valid/ready handshake to downstream logic such as the writeback or host interface. The block isolates the array from downstream backpressure: the array hands off a finished matrix in one cycle and is free to start the next tile.

## Interface
- DIM, default pkg::N: matrix dimension, ≥ 1.
- W, default pkg::NUM_BITS: element width.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- load_i  in  1  request to capture mat_i this cycle.
- mat_i  in  [W-1:0] x [DIM][DIM]  finished matrix, sampled when load is accepted.
- load_ready_o  out  1  load accepted this cycle if load_i is high (combinational).
- overrun_o  out  1  one-cycle pulse: load_i high while load_ready_o low.
- row_o  out  [W-1:0] x [DIM]  current output row/column.
- row_idx_o  out  IDX_W = max(1, $clog2(DIM))  index of row_o.
- row_valid_o  out  1  row_o is valid.
- row_ready_i  in  1  downstream accepts row_o.
- row_last_o  out  1  row_o is index DIM-1 (valid only with row_valid_o).
- done_o  out  1  one-cycle pulse the cycle after the final row handshake.

## Operation
- States: IDLE, STREAM.
- load_ready_o = (state == IDLE) | (row_valid_o & row_ready_i & row_last_o).
- Load accepted (load_i & load_ready_o):
  - mat_i is registered into the internal buffer.
  - The index is cleared to 0.
  - The next state is STREAM.
- Load not accepted: the buffer is untouched and overrun_o pulses next cycle. The rejected matrix is dropped, not queued.
- STREAM:
  - row_valid_o = 1.
  - row_o = buf[idx] (or column, see Configuration).
  - row_last_o = (idx == DIM-1).
- Handshake (row_valid_o & row_ready_i):
  - If not last: idx increments.
  - If last and no new load: go to IDLE and pulse done_o.
  - If last and load accepted: stay in STREAM with idx = 0 and the new buffer contents, and pulse done_o. This is back-to-back operation with no bubble.
- Stability: while row_valid_o & !row_ready_i, row_o, row_idx_o and row_last_o hold constant.
- The index never wraps. It only resets to 0 on load.
- DIM = 1: every row is last, and a stream takes one transfer.
- Data is pass-through: no arithmetic. Width is W in and W out, with no truncation.

## Timing
- Reset values:
  - state = IDLE, buffer = 0, idx = 0.
  - row_valid_o = 0, row_last_o = 0, row_idx_o = 0, row_o = 0.
  - done_o = 0, overrun_o = 0.
  - load_ready_o = 1 when not in reset.
- Reset asserted mid-stream aborts immediately. Outputs go to reset values asynchronously, and the buffered matrix is lost.
- Load-to-first-valid latency: 1 cycle. Load at edge k gives row_valid_o high after edge k+1.
- With row_ready_i held high, a stream occupies exactly DIM cycles of row_valid_o.
- done_o and overrun_o are registered and last one cycle.
- row_o, row_idx_o, row_valid_o and row_last_o are all registered or decoded from registered state. None of them has a combinational path from row_ready_i or load_i.

## Configuration
- CAC_DRAIN_TRANSPOSE_EN
  - Defined: output index i carries column i, so row_o[j] = buf[j][i]. Use this when the consumer wants column-major data.
  - Undefined: output index i carries row i, so row_o[j] = buf[i][j].
- Handshake, timing and reset behaviour are identical in both builds.

## Structure
- In pkg:
  - N and NUM_BITS (existing).
  - The state enum typedef drain_state_e {DRAIN_IDLE, DRAIN_STREAM}.
  - The element typedef elem_t = logic [NUM_BITS-1:0].
- One sub-module, cac_row_mux:
  - Combinational selection of row or column idx from the buffer.
  - The only place affected by CAC_DRAIN_TRANSPOSE_EN.
- FSM, index counter and buffer live in the top module.

## Test plan
All scenarios use DIM=4, W=8, mat[i][j] = 16*i+j.
- Reset, then load with row_ready_i=1:
  - rows {0,1,2,3}, {16..19}, {32..35}, {48..51} on 4 consecutive cycles.
  - row_last_o only on idx 3.
  - done_o one cycle after.
- Backpressure: row_ready_i low for 3 cycles during idx 1 → row_o holds {16,17,18,19} and idx 1 stable; resumes without loss.
- Load during STREAM at idx 1 → overrun_o pulses once and the output stream is unchanged.
- Second load in the same cycle as the idx 3 handshake:
  - next cycle shows the new matrix row 0 with no bubble.
  - done_o pulses.
- rst_i asserted at idx 2 → row_valid_o drops with no clock edge and all outputs are 0. After release, load_ready_o = 1.
- With CAC_DRAIN_TRANSPOSE_EN defined: first output {0,16,32,48}, last output {3,19,35,51}.

Source files
------------

// File: rtl/cac_row_drain_pkg.sv
// Shared types and defaults for the result-matrix row drain.
package cac_row_drain_pkg;

    localparam int N        = 4;
    localparam int NUM_BITS = 8;

    typedef enum logic [0:0] {
        DRAIN_IDLE,
        DRAIN_STREAM
    } drain_state_e;

    typedef logic [NUM_BITS-1:0] elem_t;

    // Row index width; a 1x1 matrix still needs a 1-bit index.
    function automatic int idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/cac_row_drain_if.sv
// Load-side and row-stream signals of cac_row_drain.
// The slave modport is the drain itself; the master modport is the array/consumer side.
interface cac_row_drain_if
    import cac_row_drain_pkg::*;
#(
    parameter int DIM = N,
    parameter int W   = NUM_BITS
) ();
    localparam int IDX_W = idx_width(DIM);

    logic                             load_i;
    logic [DIM-1:0][DIM-1:0][W-1:0]   mat_i;
    logic                             load_ready_o;
    logic                             overrun_o;
    logic [DIM-1:0][W-1:0]            row_o;
    logic [IDX_W-1:0]                 row_idx_o;
    logic                             row_valid_o;
    logic                             row_ready_i;
    logic                             row_last_o;
    logic                             done_o;

    modport slave (
        input  load_i, mat_i, row_ready_i,
        output load_ready_o, overrun_o, row_o, row_idx_o,
               row_valid_o, row_last_o, done_o
    );

    modport master (
        output load_i, mat_i, row_ready_i,
        input  load_ready_o, overrun_o, row_o, row_idx_o,
               row_valid_o, row_last_o, done_o
    );
endinterface

// File: rtl/cac_row_mux.sv
// Selects one row (or, with CAC_DRAIN_TRANSPOSE_EN defined, one column)
// of the buffered matrix.
module cac_row_mux #(
    parameter int DIM   = 4,
    parameter int W     = 8,
    parameter int IDX_W = 2
) (
    input  logic [DIM-1:0][DIM-1:0][W-1:0] mat_i,
    input  logic [IDX_W-1:0]               idx_i,
    output logic [DIM-1:0][W-1:0]          row_o
);

    // Gather element j of the selected row/column.
    always_comb begin
        row_o = '0;
        for (int unsigned j = 0; j < DIM; j++) begin
`ifdef CAC_DRAIN_TRANSPOSE_EN
            row_o[j] = mat_i[j][idx_i];
`else
            row_o[j] = mat_i[idx_i][j];
`endif
        end
    end

endmodule

// File: rtl/cac_row_drain.sv
// Captures a finished DIM x DIM matrix in one cycle and streams it out one
// row per valid/ready transfer. Build option CAC_DRAIN_TRANSPOSE_EN switches
// the stream to column-major order (handled entirely in cac_row_mux).
module cac_row_drain
    import cac_row_drain_pkg::*;
#(
    parameter int DIM = N,
    parameter int W   = NUM_BITS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    cac_row_drain_if.slave  bus
);

    localparam int               IDX_W    = idx_width(DIM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    drain_state_e                   state_q, state_d;
    logic [DIM-1:0][DIM-1:0][W-1:0] buf_q;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           done_q, overrun_q;

    logic row_valid;
    logic row_last;
    logic row_hs;
    logic load_ready;
    logic load_acc;

    assign row_valid  = (state_q == DRAIN_STREAM);
    assign row_last   = row_valid && (idx_q == LAST_IDX);
    assign row_hs     = row_valid && bus.row_ready_i;
    // A load is taken while idle, or in the same cycle as the final row
    // handshake so consecutive matrices stream without a bubble.
    assign load_ready = !rst_i && ((state_q == DRAIN_IDLE) || (row_hs && row_last));
    assign load_acc   = bus.load_i && load_ready;

    // Next state and index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            DRAIN_IDLE: begin
                if (load_acc) begin
                    state_d = DRAIN_STREAM;
                    idx_d   = '0;
                end
            end
            DRAIN_STREAM: begin
                if (row_hs) begin
                    if (!row_last) begin
                        idx_d = idx_q + 1'b1;
                    end else if (load_acc) begin
                        idx_d = '0;
                    end else begin
                        state_d = DRAIN_IDLE;
                    end
                end
            end
            default: begin
                state_d = DRAIN_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, index, buffer and status pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= DRAIN_IDLE;
            idx_q     <= '0;
            buf_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            if (load_acc) begin
                buf_q <= bus.mat_i;
            end
            done_q    <= row_hs && row_last;
            overrun_q <= bus.load_i && !load_ready;
        end
    end

    cac_row_mux #(
        .DIM   (DIM),
        .W     (W),
        .IDX_W (IDX_W)
    ) u_mux (
        .mat_i (buf_q),
        .idx_i (idx_q),
        .row_o (bus.row_o)
    );

    assign bus.load_ready_o = load_ready;
    assign bus.overrun_o    = overrun_q;
    assign bus.row_idx_o    = idx_q;
    assign bus.row_valid_o  = row_valid;
    assign bus.row_last_o   = row_last;
    assign bus.done_o       = done_q;

endmodule

// File: tb/tb_cac_row_drain.sv
// Scoreboard bench for cac_row_drain (DIM=4, W=8, mat[i][j] = base+16*i+j).
module tb_cac_row_drain;

    localparam int DIM = 4;
    localparam int W   = 8;

    typedef logic [DIM-1:0][W-1:0]          row_t;
    typedef logic [DIM-1:0][DIM-1:0][W-1:0] mat_t;
    typedef struct {
        row_t row;
        int   idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    cac_row_drain_if #(.DIM(DIM), .W(W)) bus ();

    cac_row_drain #(.DIM(DIM), .W(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic mat_t mk_mat(input int base);
        mat_t m;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                m[i][j] = W'(base + 16 * i + j);
        return m;
    endfunction

    function automatic row_t exp_row(input int base, input int i);
        row_t r;
        for (int j = 0; j < DIM; j++) begin
`ifdef CAC_DRAIN_TRANSPOSE_EN
            r[j] = W'(base + 16 * j + i);
`else
            r[j] = W'(base + 16 * i + j);
`endif
        end
        return r;
    endfunction

    task automatic push_mat(input int base);
        for (int i = 0; i < DIM; i++) begin
            exp_t e;
            e.row = exp_row(base, i);
            e.idx = i;
            sb.push_back(e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty;
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every valid row is compared against the queue head (so held
    // rows under backpressure are checked too); the head pops on handshake.
    always @(negedge clk) begin
        if (!rst && bus.row_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_row", 64'(bus.row_idx_o), 64'hffff);
            end else begin
                chk("row_data", 64'(bus.row_o), 64'(sb[0].row));
                chk("row_idx", 64'(bus.row_idx_o), 64'(sb[0].idx));
                chk("row_last", 64'(bus.row_last_o), 64'(sb[0].idx == DIM - 1));
                if (bus.row_ready_i) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.load_i = 1'b0;
        bus.mat_i = '0;
        bus.row_ready_i = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 64'(bus.row_valid_o), 64'd0);
        chk("rst_row", 64'(bus.row_o), 64'd0);
        chk("rst_idx", 64'(bus.row_idx_o), 64'd0);
        chk("rst_last", 64'(bus.row_last_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_overrun", 64'(bus.overrun_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_load_ready", 64'(bus.load_ready_o), 64'd1);

        // Plain stream with ready held high.
        bus.row_ready_i = 1'b1;
        bus.load_i = 1'b1;
        bus.mat_i = mk_mat(0);
        push_mat(0);
        tick();
        bus.load_i = 1'b0;
        chk("t1_first_valid", 64'(bus.row_valid_o), 64'd1);
        chk("t1_done_early", 64'(bus.done_o), 64'd0);
        repeat (3) tick();
        chk("t1_last_at3", 64'(bus.row_last_o), 64'd1);
        tick();
        chk("t1_done", 64'(bus.done_o), 64'd1);
        chk("t1_idle_valid", 64'(bus.row_valid_o), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(bus.done_o), 64'd0);
        wait_empty();

        // Backpressure at idx 1.
        bus.load_i = 1'b1;
        bus.mat_i = mk_mat(0);
        push_mat(0);
        tick();
        bus.load_i = 1'b0;
        tick();
        bus.row_ready_i = 1'b0;
        repeat (3) tick();
        chk("t2_hold_idx", 64'(bus.row_idx_o), 64'd1);
        chk("t2_hold_row", 64'(bus.row_o), 64'(exp_row(0, 1)));
        bus.row_ready_i = 1'b1;
        repeat (3) tick();
        chk("t2_done", 64'(bus.done_o), 64'd1);
        wait_empty();

        // Load while streaming at idx 1 is rejected.
        bus.load_i = 1'b1;
        bus.mat_i = mk_mat(0);
        push_mat(0);
        tick();
        bus.load_i = 1'b0;
        tick();
        bus.load_i = 1'b1;
        bus.mat_i = mk_mat(128);
        #1;
        chk("t3_load_ready_busy", 64'(bus.load_ready_o), 64'd0);
        tick();
        bus.load_i = 1'b0;
        chk("t3_overrun", 64'(bus.overrun_o), 64'd1);
        tick();
        chk("t3_overrun_pulse", 64'(bus.overrun_o), 64'd0);
        tick();
        chk("t3_done", 64'(bus.done_o), 64'd1);
        wait_empty();

        // Back-to-back load on the final handshake.
        bus.load_i = 1'b1;
        bus.mat_i = mk_mat(0);
        push_mat(0);
        tick();
        bus.load_i = 1'b0;
        repeat (3) tick();
        bus.load_i = 1'b1;
        bus.mat_i = mk_mat(128);
        push_mat(128);
        #1;
        chk("t4_load_ready_last", 64'(bus.load_ready_o), 64'd1);
        tick();
        bus.load_i = 1'b0;
        chk("t4_done", 64'(bus.done_o), 64'd1);
        chk("t4_no_bubble", 64'(bus.row_valid_o), 64'd1);
        chk("t4_idx0", 64'(bus.row_idx_o), 64'd0);
        tick();
        chk("t4_done_pulse", 64'(bus.done_o), 64'd0);
        repeat (3) tick();
        chk("t4_done2", 64'(bus.done_o), 64'd1);
        wait_empty();

        // Asynchronous reset mid-stream at idx 2.
        bus.load_i = 1'b1;
        bus.mat_i = mk_mat(0);
        push_mat(0);
        tick();
        bus.load_i = 1'b0;
        repeat (2) tick();
        chk("t5_idx2", 64'(bus.row_idx_o), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 64'(bus.row_valid_o), 64'd0);
        chk("t5_async_row", 64'(bus.row_o), 64'd0);
        chk("t5_async_idx", 64'(bus.row_idx_o), 64'd0);
        chk("t5_async_last", 64'(bus.row_last_o), 64'd0);
        chk("t5_async_done", 64'(bus.done_o), 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        #1;
        chk("t5_ready_after", 64'(bus.load_ready_o), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
